// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES block controller.
// Holds the FSM state enum, block size and the full-pad byte.
package aes_ctrl_pkg;

  localparam int BLK_BYTES = 16;

  localparam logic [7:0] PAD_FULL = 8'h10;

  typedef enum logic [2:0] {
    S_FILL,
    S_PAD,
    S_START,
    S_WAIT,
    S_XPAD
  } state_t;

endpackage

// File: rtl/aes_blk_ctrl_wait_timer.sv
// Wait timer: counts enabled cycles, flags when LIMIT cycles elapse.
// Ports: clk, rst, clear, enable in; reached out (last allowed cycle).
module wait_timer #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic reached
);

  localparam int W = $clog2(LIMIT) + 1;

  logic [W-1:0] count;

  // count is 0 in the first enabled cycle, so this marks cycle LIMIT
  assign reached = enable && (count == W'(LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !reached) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/aes_blk_ctrl.sv
// Packs packet bytes into 16-byte AES blocks with PKCS#7 padding.
// Ports: wr_* byte in, full; aes_block/start/last/done core side; status.
module aes_blk_ctrl #(
  parameter int WAIT_LIMIT = 64,
  parameter int BLK_BYTES  = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   wr_data,
  input  logic         wr_en,
  input  logic         wr_eop,
  output logic         full,
  output logic [127:0] aes_block,
  output logic         aes_start,
  output logic         aes_last,
  input  logic         aes_done,
  output logic [15:0]  blk_count,
  output logic         ovf_err,
  output logic         tmo_err
);

  import aes_ctrl_pkg::*;

  localparam logic [3:0] LAST = 4'(BLK_BYTES - 1);

  state_t       state, state_d;
  logic [3:0]   cnt, cnt_d;
  logic         xpad, xpad_d;
  logic [127:0] blk, blk_d;
  logic         last, last_d;
  logic [15:0]  bcnt, bcnt_d;
  logic         ovf, ovf_d;
  logic         tmo, tmo_d;
  logic         in_wait;
  logic         tmr_hit;
  logic [7:0]   pad_n;

  assign in_wait = (state == S_WAIT);

  wait_timer #(
    .LIMIT(WAIT_LIMIT)
  ) u_tmr (
    .clk    (clk),
    .rst    (rst),
    .clear  (!in_wait),
    .enable (in_wait),
    .reached(tmr_hit)
  );

  // cnt holds the index of the eop byte, so N = 15 - cnt
  assign pad_n = {4'h0, LAST - cnt};

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    xpad_d  = xpad;
    blk_d   = blk;
    last_d  = last;
    bcnt_d  = bcnt;
    ovf_d   = ovf | (wr_en & (state != S_FILL));
    tmo_d   = tmo;
    unique case (state)
      S_FILL: begin
        if (wr_en) begin
          blk_d[{LAST - cnt, 3'b000} +: 8] = wr_data;
          if (cnt == LAST) begin
            state_d = S_START;
            cnt_d   = '0;
            last_d  = 1'b0;
            xpad_d  = wr_eop;
          end else if (wr_eop) begin
            state_d = S_PAD;
          end else begin
            cnt_d = cnt + 4'd1;
          end
        end
      end
      S_PAD: begin
        for (int i = 0; i < BLK_BYTES; i++) begin
          if (4'(i) > cnt) begin
            blk_d[8*(BLK_BYTES-1-i) +: 8] = pad_n;
          end
        end
        last_d  = 1'b1;
        cnt_d   = '0;
        state_d = S_START;
      end
      S_START: begin
        bcnt_d  = bcnt + 16'd1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // done wins over a timeout landing in the same cycle
        if (aes_done) begin
          state_d = xpad ? S_XPAD : S_FILL;
          cnt_d   = '0;
        end else if (tmr_hit) begin
          tmo_d   = 1'b1;
          cnt_d   = '0;
          xpad_d  = 1'b0;
          state_d = S_FILL;
        end
      end
      S_XPAD: begin
        blk_d   = {16{PAD_FULL}};
        last_d  = 1'b1;
        xpad_d  = 1'b0;
        state_d = S_START;
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FILL;
      cnt   <= '0;
      xpad  <= 1'b0;
      blk   <= '0;
      last  <= 1'b0;
      bcnt  <= '0;
      ovf   <= 1'b0;
      tmo   <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      xpad  <= xpad_d;
      blk   <= blk_d;
      last  <= last_d;
      bcnt  <= bcnt_d;
      ovf   <= ovf_d;
      tmo   <= tmo_d;
    end
  end

  assign full      = (state != S_FILL);
  assign aes_start = (state == S_START);
  assign aes_block = blk;
  assign aes_last  = last;
  assign blk_count = bcnt;
  assign ovf_err   = ovf;
  assign tmo_err   = tmo;

endmodule

// File: tb/tb_aes_blk_ctrl.sv
// Testbench for aes_blk_ctrl: table vectors, corner sequences,
// and random packets against a PKCS#7 block reference model.
module tb_aes_blk_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   wr_data = '0;
  logic         wr_en = 1'b0;
  logic         wr_eop = 1'b0;
  logic         full;
  logic [127:0] aes_block;
  logic         aes_start;
  logic         aes_last;
  logic         aes_done;
  logic [15:0]  blk_count;
  logic         ovf_err;
  logic         tmo_err;

  always #5 clk = ~clk;

  aes_blk_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .wr_eop   (wr_eop),
    .full     (full),
    .aes_block(aes_block),
    .aes_start(aes_start),
    .aes_last (aes_last),
    .aes_done (aes_done),
    .blk_count(blk_count),
    .ovf_err  (ovf_err),
    .tmo_err  (tmo_err)
  );

  typedef struct {
    logic [127:0] blk;
    logic         last;
  } blk_t;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    int           len;
    logic [7:0]   base;
    logic [7:0]   step;
    bit           eop;
    int           nblk;
    logic [127:0] e0;
    bit           l0;
    logic [127:0] e1;
    bit           l1;
  } vec_t;

  blk_t exp_q[$];
  blk_t cap_q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;
  int   done_delay = 4;
  bit   done_auto = 1'b1;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // capture every issued block; start must be a single-cycle pulse
  initial begin
    forever begin
      @(negedge clk);
      if (aes_start === 1'b1) begin
        cap_q.push_back('{aes_block, aes_last});
        @(negedge clk);
        chk("start_pulse", 128'(aes_start), 128'd0);
      end
    end
  end

  // AES core stand-in: raise done in wait cycle done_delay
  initial begin
    int w;
    w = -1;
    aes_done = 1'b0;
    forever begin
      @(negedge clk);
      aes_done = 1'b0;
      if (aes_start === 1'b1) w = 0;
      else if (w >= 0) w++;
      if (done_auto && w == done_delay) begin
        aes_done = 1'b1;
        w = -1;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // reference: split into 16-byte blocks, PKCS#7 pad the tail on eop
  function automatic void model(input bq_t d, input bit eop);
    int n;
    int i;
    int rem;
    logic [127:0] b;
    n = d.size();
    i = 0;
    while (n - i >= 16) begin
      for (int k = 0; k < 16; k++) b[127-8*k -: 8] = d[i+k];
      exp_q.push_back('{b, 1'b0});
      exp_cnt++;
      i += 16;
    end
    if (eop) begin
      rem = n - i;
      for (int k = 0; k < 16; k++)
        b[127-8*k -: 8] = (k < rem) ? d[i+k] : 8'(16 - rem);
      exp_q.push_back('{b, 1'b1});
      exp_cnt++;
    end
  endfunction

  task automatic send(input bq_t d, input bit eop);
    int k;
    foreach (d[i]) begin
      k = 0;
      while (full !== 1'b0 && k < 500) begin
        @(negedge clk);
        k++;
      end
      if (k >= 500) begin
        checks++;
        errors++;
        $display("FAIL send_wait: full got %b expected 0", full);
        return;
      end
      wr_en = 1'b1;
      wr_data = d[i];
      wr_eop = eop && (i == d.size() - 1);
      @(negedge clk);
      wr_en = 1'b0;
      wr_eop = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name, input int nexp);
    int k;
    k = 0;
    while ((cap_q.size() < nexp || full !== 1'b0) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= 2000) begin
      errors++;
      $display("FAIL %s_idle: got %0d blocks expected %0d",
               name, cap_q.size(), nexp);
    end
  endtask

  task automatic drain(input string name);
    blk_t e;
    blk_t c;
    wait_idle(name, exp_q.size());
    chk({name, "_nblk"}, 128'(cap_q.size()), 128'(exp_q.size()));
    while (exp_q.size() > 0 && cap_q.size() > 0) begin
      e = exp_q.pop_front();
      c = cap_q.pop_front();
      chk({name, "_blk"}, c.blk, e.blk);
      chk({name, "_last"}, 128'(c.last), 128'(e.last));
    end
    exp_q.delete();
    cap_q.delete();
    chk({name, "_cnt"}, 128'(blk_count), 128'(exp_cnt[15:0]));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_full", 128'(full), 128'd0);
    chk("rst_start", 128'(aes_start), 128'd0);
    chk("rst_last", 128'(aes_last), 128'd0);
    chk("rst_block", aes_block, 128'd0);
    chk("rst_count", 128'(blk_count), 128'd0);
    chk("rst_ovf", 128'(ovf_err), 128'd0);
    chk("rst_tmo", 128'(tmo_err), 128'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    cap_q.delete();
    exp_cnt = 0;
  endtask

  function automatic bq_t ramp(input int len, input logic [7:0] base,
                               input logic [7:0] step);
    bq_t d;
    for (int i = 0; i < len; i++) d.push_back(base + 8'(i) * step);
    return d;
  endfunction

  initial begin
    vec_t tbl[5];
    bq_t  d;
    int   len;
    bit   eop;

    tbl[0] = '{16, 8'h00, 8'h01, 1'b0, 1,
               128'h00010203_04050607_08090a0b_0c0d0e0f, 1'b0,
               128'h0, 1'b0};
    tbl[1] = '{5, 8'haa, 8'h00, 1'b1, 1,
               128'haaaaaaaa_aa0b0b0b_0b0b0b0b_0b0b0b0b, 1'b1,
               128'h0, 1'b0};
    tbl[2] = '{16, 8'h11, 8'h00, 1'b1, 2,
               128'h11111111_11111111_11111111_11111111, 1'b0,
               128'h10101010_10101010_10101010_10101010, 1'b1};
    tbl[3] = '{15, 8'h20, 8'h01, 1'b1, 1,
               128'h20212223_24252627_28292a2b_2c2d2e01, 1'b1,
               128'h0, 1'b0};
    tbl[4] = '{1, 8'h7f, 8'h00, 1'b1, 1,
               128'h7f0f0f0f_0f0f0f0f_0f0f0f0f_0f0f0f0f, 1'b1,
               128'h0, 1'b0};

    do_reset();

    foreach (tbl[t]) begin
      blk_t c;
      send(ramp(tbl[t].len, tbl[t].base, tbl[t].step), tbl[t].eop);
      exp_cnt += tbl[t].nblk;
      wait_idle("tbl", tbl[t].nblk);
      chk("tbl_nblk", 128'(cap_q.size()), 128'(tbl[t].nblk));
      if (cap_q.size() > 0) begin
        c = cap_q.pop_front();
        chk("tbl_blk0", c.blk, tbl[t].e0);
        chk("tbl_last0", 128'(c.last), 128'(tbl[t].l0));
      end
      if (tbl[t].nblk > 1 && cap_q.size() > 0) begin
        c = cap_q.pop_front();
        chk("tbl_blk1", c.blk, tbl[t].e1);
        chk("tbl_last1", 128'(c.last), 128'(tbl[t].l1));
      end
      cap_q.delete();
      chk("tbl_cnt", 128'(blk_count), 128'(exp_cnt));
    end

    // overflow: write while the block is out to the core
    done_delay = 20;
    d = ramp(16, 8'h40, 8'h01);
    model(d, 1'b0);
    send(d, 1'b0);
    chk("ovf_full", 128'(full), 128'd1);
    chk("ovf_pre", 128'(ovf_err), 128'd0);
    wr_en = 1'b1;
    wr_data = 8'hee;
    @(negedge clk);
    wr_en = 1'b0;
    chk("ovf_set", 128'(ovf_err), 128'd1);
    drain("ovf");
    d = ramp(16, 8'h80, 8'h03);
    model(d, 1'b0);
    send(d, 1'b0);
    drain("ovf_next");
    chk("ovf_sticky", 128'(ovf_err), 128'd1);

    // done exactly in the last allowed wait cycle is not a timeout
    do_reset();
    done_delay = 64;
    d = ramp(16, 8'h01, 8'h01);
    model(d, 1'b0);
    send(d, 1'b0);
    drain("edge");
    chk("edge_tmo", 128'(tmo_err), 128'd0);

    // timeout; pending extra pad block must be dropped
    done_auto = 1'b0;
    d = ramp(16, 8'h33, 8'h00);
    send(d, 1'b1);
    chk("tmo_start", 128'(aes_start), 128'd1);
    exp_q.push_back('{{16{8'h33}}, 1'b0});
    exp_cnt++;
    repeat (64) @(negedge clk);
    chk("tmo_wait_full", 128'(full), 128'd1);
    chk("tmo_wait_err", 128'(tmo_err), 128'd0);
    @(negedge clk);
    chk("tmo_full", 128'(full), 128'd0);
    chk("tmo_err", 128'(tmo_err), 128'd1);
    repeat (4) @(negedge clk);
    drain("tmo");
    done_auto = 1'b1;
    done_delay = 3;
    d = ramp(16, 8'hc0, 8'h01);
    model(d, 1'b0);
    send(d, 1'b0);
    drain("tmo_next");
    chk("tmo_sticky", 128'(tmo_err), 128'd1);

    // reset mid-block discards the partial bytes
    send(ramp(7, 8'h55, 8'h01), 1'b0);
    do_reset();
    repeat (6) @(negedge clk);
    chk("rst_nostart", 128'(cap_q.size()), 128'd0);
    d = ramp(16, 8'h90, 8'h01);
    model(d, 1'b0);
    send(d, 1'b0);
    drain("rst_clean");

    // reset mid-wait: no block reissued after release
    done_auto = 1'b0;
    send(ramp(16, 8'h61, 8'h00), 1'b0);
    repeat (3) @(negedge clk);
    do_reset();
    done_auto = 1'b1;
    repeat (6) @(negedge clk);
    chk("rstw_nostart", 128'(cap_q.size()), 128'd0);

    // random packets against the model
    for (int p = 0; p < 25; p++) begin
      d.delete();
      if ($urandom_range(0, 3) == 0) begin
        len = 16 * $urandom_range(1, 2);
        eop = 1'($urandom_range(0, 1));
      end else begin
        len = $urandom_range(1, 40);
        eop = 1'b1;
      end
      for (int i = 0; i < len; i++) d.push_back(8'($urandom));
      done_delay = $urandom_range(1, 30);
      model(d, eop);
      send(d, eop);
      drain("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
